can_crc_unit: RTL and testbench
===============================

# can_crc_unit

Parametrised serial CRC engine and checker for the CAN receive path. It sits after the bit destuffer and consumes one destuffed bit per `bit_valid` strobe. It accumulates the CRC over the frame's data bits, captures the transmitted CRC field, and issues a one-cycle verdict. It supersedes the compare-only checker: CRC generation, field capture, comparison and error statistics are all contained in one block.

## Interface
- `CRC_W`, 15: CRC width in bits; legal range 8..32.
- `POLY`, 15'h4599: generator polynomial with the implicit x^CRC_W term omitted.
- `INIT`, 0: CRC register value loaded on `start`.
- `CNT_W`, 8: width of the error counter.

Ports (clock and reset first):
- `clock`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block enable; low applies a synchronous clear to IDLE.
- `start`  in  1  pulse; begins a frame from any state.
- `bit_valid`  in  1  qualifies `bit_in` for one cycle.
- `bit_in`  in  1  destuffed serial bit, transmitted order.
- `data_done`  in  1  pulse; the last data bit has been delivered, so subsequent bits are CRC field.
- `cnt_clr`  in  1  synchronous clear of `err_count`.
- `busy`  out  1  high in CALC or RECV.
- `crc_value`  out  CRC_W  running or final calculated CRC.
- `crc_valid`  out  1  one-cycle verdict strobe.
- `crc_error`  out  1  mismatch flag; meaningful only with `crc_valid`.
- `err_count`  out  CNT_W  saturating count of mismatches.

## Operation
- States:
  - IDLE (reset state).
  - CALC: accumulating data bits.
  - RECV: capturing the CRC field.
  - DONE: one cycle, issues the verdict.
- Transitions:
  - `start` → CALC from any state, with `crc_reg`←INIT, `rx_sr`←0, `rx_cnt`←0. `start` wins over every other input in the same cycle.
  - CALC + `data_done` → RECV.
  - RECV + `rx_cnt` reaching CRC_W → DONE.
  - DONE → IDLE unconditionally.
- CALC update on `bit_valid`: `fb = bit_in ^ crc_reg[CRC_W-1]`; `crc_reg ← (crc_reg << 1)` truncated to CRC_W, then XOR with POLY if `fb`.
- `bit_valid` and `data_done` in the same CALC cycle: the bit is processed as data first, then the state moves to RECV.
- RECV on `bit_valid`: `rx_sr ← {rx_sr[CRC_W-2:0], bit_in}` (MSB first), and `rx_cnt` increments. `crc_reg` is frozen.
- DONE:
  - `crc_valid` = 1 for exactly one cycle.
  - `crc_error = (rx_sr != crc_reg)`.
  - `err_count` increments when `crc_error` is set, saturating at all-ones.
- `bit_valid` in IDLE or DONE is ignored. `data_done` outside CALC is ignored.
- `crc_value` always reflects `crc_reg`; after the verdict it holds until the next `start`.
- `enable` low: synchronously returns to IDLE, clears `crc_reg`, `rx_sr`, `rx_cnt`, `crc_valid` and `crc_error`. `err_count` is retained.
- `cnt_clr` has priority over an increment in the same cycle.

## Timing
- Reset values: `busy`=0, `crc_value`=0, `crc_valid`=0, `crc_error`=0, `err_count`=0. State is IDLE.
- CRC update latency: `crc_value` reflects a bit one cycle after its `bit_valid`.
- Verdict latency: the CRC_W-th RECV `bit_valid` at cycle N gives DONE at N+1, which drives `crc_valid`/`crc_error` as registered outputs. Both are visible on the cycle after DONE is entered; they are then cleared and the state is IDLE.
- `start` during RECV or DONE aborts the frame: no `crc_valid` is issued and `err_count` is unchanged.
- `reset_n` assertion mid-frame: all state clears immediately and asynchronously.
- Back-to-back frames: `start` in the cycle after the verdict is legal; no dead cycle is required.

## Configuration
- `CAN_CRC_ERR_CNT_EN`:
  - Defined: `err_count` and `cnt_clr` behave as specified.
  - Undefined: the counter logic is removed, `err_count` is tied to 0, and `cnt_clr` is ignored. All other behaviour is identical.

## Test plan
- Reset, then `start`, one data bit 1, `data_done` → `crc_value`=15'h4599. Send the 15 CRC bits of 0x4599 → one `crc_valid` with `crc_error`=0, and `err_count`=0.
- Data bits 1,1 → `crc_value`=15'h0B32. Send received CRC 0x0B33 → `crc_valid`=1, `crc_error`=1, `err_count`=1.
- Ten zero data bits with INIT=0 → `crc_value`=0. Send received CRC 0 → pass. Check that `bit_valid` gaps of 0..3 idle cycles do not change the result.
- `bit_valid` and `data_done` together on the last data bit → that bit is counted as data. Then `start` issued after 7 CRC bits → no `crc_valid`, state CALC, `crc_value`=INIT.
- 300 consecutive mismatching frames with CNT_W=8 → `err_count` saturates at 255. `cnt_clr` together with a mismatch verdict → `err_count`=0.
- `reset_n` pulsed low mid-RECV → all outputs 0 at once. `enable` low for one cycle mid-CALC → IDLE with `crc_value`=0 and `err_count` retained. Rebuild without `CAN_CRC_ERR_CNT_EN` → `err_count` stays 0.

Source files
------------

// File: rtl/can_crc_unit.sv
// Serial CAN CRC engine/checker: accumulates data-bit CRC, captures the received CRC field, issues a one-cycle verdict.
// Optional saturating mismatch counter enabled by defining CAN_CRC_ERR_CNT_EN (otherwise err_count is tied to 0).
module can_crc_unit #(
  parameter int              CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY = 15'h4599,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter int              CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             data_done,
  input  logic             cnt_clr,
  output logic             busy,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_valid,
  output logic             crc_error,
  output logic [CNT_W-1:0] err_count
);

  localparam int RC_W = $clog2(CRC_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, RECV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] rx_sr;
  logic [RC_W-1:0]  rx_cnt;
  logic [CRC_W-1:0] crc_next;
  logic             fb;
  logic             last_rx_bit;

  assign fb          = bit_in ^ crc_reg[CRC_W-1];
  assign crc_next    = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign last_rx_bit = bit_valid && (rx_cnt == RC_W'(CRC_W - 1));
  assign crc_value   = crc_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = CALC;
    end else begin
      case (state)
        CALC:    if (data_done)   state_nxt = RECV;
        RECV:    if (last_rx_bit) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == CALC) || (state == RECV);
  end

  // Verdict flags are registered out of DONE, so they appear the cycle after DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_reg   <= '0;
      rx_sr     <= '0;
      rx_cnt    <= '0;
      crc_valid <= 1'b0;
      crc_error <= 1'b0;
    end else if (!enable) begin
      crc_reg   <= '0;
      rx_sr     <= '0;
      rx_cnt    <= '0;
      crc_valid <= 1'b0;
      crc_error <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      crc_error <= 1'b0;
      if (start) begin
        crc_reg <= INIT;
        rx_sr   <= '0;
        rx_cnt  <= '0;
      end else begin
        case (state)
          CALC: if (bit_valid) crc_reg <= crc_next;
          RECV: if (bit_valid) begin
            rx_sr  <= {rx_sr[CRC_W-2:0], bit_in};
            rx_cnt <= rx_cnt + RC_W'(1);
          end
          DONE: begin
            crc_valid <= 1'b1;
            crc_error <= (rx_sr != crc_reg);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CAN_CRC_ERR_CNT_EN
  logic mismatch_now;
  assign mismatch_now = enable && !start && (state == DONE) && (rx_sr != crc_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (cnt_clr)
      err_count <= '0;
    else if (mismatch_now && (err_count != '1))
      err_count <= err_count + CNT_W'(1);
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_can_crc_unit.sv
// Directed + randomized bench for can_crc_unit; expected CRCs come from polynomial long division.
module tb_can_crc_unit;

  logic        clock = 1'b0;
  logic        reset_n, enable, start, bit_valid, bit_in, data_done, cnt_clr;
  logic        busy, crc_valid, crc_error;
  logic [14:0] crc_value;
  logic [7:0]  err_count;

  int n_chk  = 0;
  int n_fail = 0;
  int model_err = 0;

`ifdef CAN_CRC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  can_crc_unit dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
    .bit_valid(bit_valid), .bit_in(bit_in), .data_done(data_done), .cnt_clr(cnt_clr),
    .busy(busy), .crc_value(crc_value), .crc_valid(crc_valid), .crc_error(crc_error),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC = remainder of (message * x^15) divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
  function automatic logic [14:0] ref_crc(input bit msg[$]);
    int unsigned acc = 0;
    bit aug[$];
    aug = msg;
    for (int i = 0; i < 15; i++) aug.push_back(1'b0);
    foreach (aug[i]) begin
      acc = (acc << 1) | 32'(aug[i]);
      if (acc[15]) acc = acc ^ 32'hC599;
    end
    return acc[14:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    bit_valid = 1'b0;
    for (int g = 0; g < n; g++) begin
      bit_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_bit(input bit b, input bit dd);
    bit_valid = 1'b1;
    bit_in    = b;
    data_done = dd;
    tick();
    bit_valid = 1'b0;
    data_done = 1'b0;
  endtask

  task automatic send_field(input logic [14:0] v, input int maxgap);
    for (int i = 14; i >= 0; i--) begin
      idle_gap($urandom_range(maxgap, 0));
      send_bit(v[i], 1'b0);
    end
  endtask

  task automatic check_verdict(input bit exp_err, input bit clr);
    check("pre_verdict_valid", crc_valid, 0);
    check("done_busy", busy, 0);
    cnt_clr = clr;
    tick();
    cnt_clr = 1'b0;
    if (!CNT_EN || clr) model_err = 0;
    else if (exp_err && model_err < 255) model_err++;
    check("verdict_valid", crc_valid, 1);
    check("verdict_error", crc_error, 32'(exp_err));
    check("err_count", err_count, model_err);
    tick();
    check("post_verdict_valid", crc_valid, 0);
  endtask

  // One full frame: random data, optional joint data_done, received CRC optionally corrupted.
  task automatic run_frame(input bit msg[$], input bit joint, input bit corrupt, input int maxgap,
                           input bit clr);
    logic [14:0] exp_crc, rx;
    pulse_start();
    check("start_crc_init", crc_value, 0);
    foreach (msg[i]) begin
      idle_gap($urandom_range(maxgap, 0));
      send_bit(msg[i], joint && (i == msg.size() - 1));
    end
    if (!(joint && msg.size() > 0)) begin
      data_done = 1'b1;
      tick();
      data_done = 1'b0;
    end
    exp_crc = ref_crc(msg);
    check("data_crc", crc_value, exp_crc);
    rx = exp_crc;
    if (corrupt) rx[$urandom_range(14, 0)] ^= 1'b1;
    send_field(rx, maxgap);
    check("crc_frozen", crc_value, exp_crc);
    check_verdict(corrupt, clr);
  endtask

  initial begin
    bit q[$];
    int seen;
    logic [7:0] held;

    reset_n = 1'b0; enable = 1'b1; start = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; data_done = 1'b0; cnt_clr = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_crc", crc_value, 0);
    check("rst_valid", crc_valid, 0);
    check("rst_error", crc_error, 0);
    check("rst_cnt", err_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Single data bit 1, correct CRC
    pulse_start();
    send_bit(1'b1, 1'b0);
    data_done = 1'b1; tick(); data_done = 1'b0;
    check("one_bit_crc", crc_value, 15'h4599);
    send_field(15'h4599, 0);
    check_verdict(1'b0, 1'b0);

    // Data 1,1 with wrong received CRC
    pulse_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    data_done = 1'b1; tick(); data_done = 1'b0;
    check("two_bit_crc", crc_value, 15'h0B32);
    send_field(15'h0B33, 0);
    check_verdict(1'b1, 1'b0);

    // Ten zeros with 0..3 idle gaps
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(1'b0);
    run_frame(q, 1'b0, 1'b0, 3, 1'b0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(40, 1)); i++) q.push_back(1'($urandom));
      run_frame(q, 1'($urandom), 1'($urandom), 3, 1'b0);
    end

    // Joint data_done on last bit, then abort after 7 CRC bits
    q = {1'b1, 1'b0, 1'b1};
    pulse_start();
    foreach (q[i]) send_bit(q[i], i == 2);
    check("joint_crc", crc_value, ref_crc(q));
    bit_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin bit_in = 1'($urandom); tick(); end
    bit_valid = 1'b0;
    held = err_count;
    pulse_start();
    check("abort_busy", busy, 1);
    check("abort_crc_init", crc_value, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (crc_valid) seen++;
    end
    check("abort_no_verdict", seen, 0);
    check("abort_busy_calc", busy, 1);
    check("abort_cnt_held", err_count, held);

    // Saturation over 300 mismatching frames, then cnt_clr with a mismatch verdict
    for (int f = 0; f < 300; f++) begin
      q = {};
      run_frame(q, 1'b0, 1'b1, 0, 1'b0);
    end
    check("sat_cnt", err_count, CNT_EN ? 255 : 0);
    q = {1'b1};
    run_frame(q, 1'b0, 1'b1, 0, 1'b1);

    // Build up a nonzero count, then async reset mid-RECV
    q = {1'b0, 1'b1};
    run_frame(q, 1'b0, 1'b1, 0, 1'b0);
    pulse_start();
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_crc", crc_value, 0);
    check("arst_valid", crc_valid, 0);
    check("arst_error", crc_error, 0);
    check("arst_cnt", err_count, 0);
    model_err = 0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // enable low for one cycle mid-CALC
    q = {1'b1, 1'b1, 1'b0};
    run_frame(q, 1'b1, 1'b1, 1, 1'b0);
    held = err_count;
    pulse_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("dis_busy", busy, 0);
    check("dis_crc", crc_value, 0);
    check("dis_cnt_kept", err_count, held);
    send_bit(1'b1, 1'b1);
    check("idle_bit_ignored", crc_value, 0);
    check("idle_busy", busy, 0);

    // Back-to-back frame after the verdict
    q = {1'b1, 1'b0, 1'b0, 1'b1};
    run_frame(q, 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
